scan_decoder: RTL and testbench

//   Parametrised, registered N-to-2^N one-hot decoder with enable, output polarity

---
 rtl/scan_decoder_pkg.sv | 15 +
 rtl/scan_decoder_if.sv | 25 ++
 rtl/scan_decoder_onehot_dec.sv | 15 +
 rtl/scan_decoder.sv | 80 ++++++++
 tb/tb_scan_decoder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encodings and the per-cycle
// register action selected by the next-state logic.
package scan_decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_LOAD,
      ACT_ADVANCE,
      ACT_COUNT
   } act_e;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_if.sv
// Control/status bundle between lab control logic (master) and the scan
// decoder (slave).
interface scan_decoder_if #(
   parameter int SEL_W = 4,
   parameter int DIV_W = 16
);
   logic                  en;
   logic                  mode;
   logic [SEL_W-1:0]      sel_in;
   logic                  load;
   logic [DIV_W-1:0]      tick_div;
   logic [2**SEL_W-1:0]   dout;
   logic [SEL_W-1:0]      sel_out;
   logic                  wrap;

   modport master (
      output en, mode, sel_in, load, tick_div,
      input  dout, sel_out, wrap
   );

   modport slave (
      input  en, mode, sel_in, load, tick_div,
      output dout, sel_out, wrap
   );
endinterface : scan_decoder_if

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder; all zeros when en_i is low.
module onehot_dec #(
   parameter int SEL_W = 4
) (
   input  logic [SEL_W-1:0]    sel_i,
   input  logic                en_i,
   output logic [2**SEL_W-1:0] onehot_o
);
   genvar gi;
   generate
      for (gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
         assign onehot_o[gi] = en_i && (sel_i == SEL_W'(gi));
      end
   endgenerate
endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// Registered one-hot/one-cold decoder with direct and self-advancing scan
// modes; holds the select register, prescaler, wrap flop and output register.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 4,
   parameter int DIV_W      = 16,
   parameter int ACTIVE_LOW = 0
) (
   input  logic           clk,
   input  logic           rst,
   scan_decoder_if.slave  bus
);
   localparam int               OUT_W     = 2**SEL_W;
   localparam logic [SEL_W-1:0] SEL_MAX   = {SEL_W{1'b1}};
   localparam logic [OUT_W-1:0] DOUT_IDLE = {OUT_W{ACTIVE_LOW != 0}};

   act_e             act;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic             wrap_q, wrap_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic [OUT_W-1:0] onehot;

   // >= rather than == so a tick_div lowered under the running count still terminates.
   always_comb begin
      act = ACT_HOLD;
      if (!bus.en)                         act = ACT_HOLD;
      else if (bus.mode == MODE_DIRECT)    act = ACT_LOAD;
      else if (bus.load)                   act = ACT_LOAD;
      else if (presc_q >= bus.tick_div)    act = ACT_ADVANCE;
      else                                 act = ACT_COUNT;
   end

   always_comb begin
      sel_d   = sel_q;
      presc_d = presc_q;
      wrap_d  = 1'b0;
      case (act)
         ACT_LOAD: begin
            sel_d   = bus.sel_in;
            presc_d = '0;
         end
         ACT_ADVANCE: begin
            sel_d   = sel_q + SEL_W'(1);
            presc_d = '0;
            wrap_d  = (sel_q == SEL_MAX);
         end
         ACT_COUNT: presc_d = presc_q + DIV_W'(1);
         default: ;
      endcase
   end

   // Decoding the next select keeps dout aligned with sel_out on the same edge.
   onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .sel_i    (sel_d),
      .en_i     (bus.en),
      .onehot_o (onehot)
   );

   assign dout_d = (ACTIVE_LOW != 0) ? ~onehot : onehot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= '0;
         presc_q <= '0;
         wrap_q  <= 1'b0;
         dout_q  <= DOUT_IDLE;
      end else begin
         sel_q   <= sel_d;
         presc_q <= presc_d;
         wrap_q  <= wrap_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.sel_out = sel_q;
   assign bus.wrap    = wrap_q;
endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Directed and randomized checks of scan_decoder against a behavioural model;
// a second instance covers ACTIVE_LOW=1 with SEL_W=3.
module tb_scan_decoder;
   import scan_decoder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   scan_decoder_if #(.SEL_W(4), .DIV_W(16)) bus ();
   scan_decoder_if #(.SEL_W(3), .DIV_W(16)) bus2 ();

   scan_decoder #(.SEL_W(4), .DIV_W(16), .ACTIVE_LOW(0)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   scan_decoder #(.SEL_W(3), .DIV_W(16), .ACTIVE_LOW(1)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   int errors = 0;
   int checks = 0;

   // Reference state: select value, prescaler count, last wrap pulse and dout.
   int          m_sel   = 0;
   int          m_presc = 0;
   bit          m_wrap  = 1'b0;
   logic [15:0] m_dout  = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_sel = 0; m_presc = 0; m_wrap = 1'b0; m_dout = 16'h0000;
      end else if (!bus.en) begin
         m_wrap = 1'b0;
         m_dout = 16'h0000;
      end else begin
         m_wrap = 1'b0;
         if (bus.mode == MODE_DIRECT || bus.load) begin
            m_sel   = int'(bus.sel_in);
            m_presc = 0;
         end else if (m_presc >= int'(bus.tick_div)) begin
            m_presc = 0;
            if (m_sel == 15) begin
               m_sel  = 0;
               m_wrap = 1'b1;
            end else begin
               m_sel = m_sel + 1;
            end
         end else begin
            m_presc = m_presc + 1;
         end
         m_dout = 16'h0001 << m_sel;
      end
   endtask

   task automatic check_model();
      check("sel_out", 32'(bus.sel_out), 32'(m_sel));
      check("dout",    32'(bus.dout),    32'(m_dout));
      check("wrap",    32'(bus.wrap),    32'(m_wrap));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_model();
      $display("t=%0t en=%0b mode=%0b load=%0b sel_in=%0d tick=%0d sel_out=%0d dout=%h wrap=%0b",
               $time, bus.en, bus.mode, bus.load, bus.sel_in, bus.tick_div,
               bus.sel_out, bus.dout, bus.wrap);
   endtask

   initial begin
      int wraps;
      int prev_sel;
      bit found;

      bus.en = 1'b0; bus.mode = MODE_DIRECT; bus.sel_in = '0; bus.load = 1'b0; bus.tick_div = '0;
      bus2.en = 1'b0; bus2.mode = MODE_DIRECT; bus2.sel_in = '0; bus2.load = 1'b0; bus2.tick_div = '0;

      // Asynchronous reset between clock edges.
      #2 rst = 1'b1;
      #1;
      model_update();
      check("rst_sel_out", 32'(bus.sel_out), 32'd0);
      check("rst_dout",    32'(bus.dout),    32'h0000);
      check("rst_wrap",    32'(bus.wrap),    32'd0);
      check("al_rst_dout", 32'(bus2.dout),   32'h00FF);
      step();
      rst = 1'b0;

      bus2.en = 1'b1; bus2.sel_in = 3'd3;
      step();
      check("al_direct_dout", 32'(bus2.dout), 32'h00F7);

      // Direct mode.
      bus.en = 1'b1; bus.mode = MODE_DIRECT; bus.sel_in = 4'd9;
      step();
      check("direct9_dout", 32'(bus.dout),    32'h0200);
      check("direct9_sel",  32'(bus.sel_out), 32'd9);
      for (int i = 0; i < 16; i++) begin
         bus.sel_in = 4'(i);
         step();
         check("sweep_dout", 32'(bus.dout), 32'h1 << i);
      end

      // Scan from sel=0 with dwell of 3 cycles.
      bus.sel_in = 4'd0;
      step();
      bus.mode = MODE_SCAN; bus.tick_div = 16'd2;
      wraps = 0;
      for (int c = 1; c <= 48; c++) begin
         step();
         if (bus.wrap) wraps++;
         if (c == 2) check("scan_dwell", 32'(bus.sel_out), 32'd0);
         if (c == 3) check("scan_first_adv", 32'(bus.sel_out), 32'd1);
      end
      check("scan48_sel",  32'(bus.sel_out), 32'd0);
      check("scan48_wrap", 32'(bus.wrap),    32'd1);
      check("scan_wraps",  32'(wraps),       32'd1);
      step();
      check("wrap_one_cycle", 32'(bus.wrap), 32'd0);

      // Load in the terminal-count cycle at sel=15 beats the advance.
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         step();
         if (m_sel == 15 && m_presc == 2) found = 1'b1;
      end
      check("find_tc_at_15", 32'(found), 32'd1);
      bus.load = 1'b1; bus.sel_in = 4'd5;
      step();
      check("load_sel",  32'(bus.sel_out), 32'd5);
      check("load_wrap", 32'(bus.wrap),    32'd0);
      bus.load = 1'b0;
      step();
      step();
      check("load_dwell", 32'(bus.sel_out), 32'd5);
      step();
      check("load_next_adv", 32'(bus.sel_out), 32'd6);

      // Enable low freezes select and blanks outputs.
      bus.en = 1'b0;
      prev_sel = m_sel;
      for (int c = 0; c < 3; c++) begin
         step();
         check("en0_dout", 32'(bus.dout),    32'h0000);
         check("en0_sel",  32'(bus.sel_out), 32'(prev_sel));
      end
      bus.en = 1'b1;
      step();

      // tick_div lowered below the running prescaler still terminates.
      bus.load = 1'b1; bus.sel_in = 4'd7;
      step();
      bus.load = 1'b0; bus.tick_div = 16'd5;
      for (int c = 0; c < 4; c++) step();
      bus.tick_div = 16'd1;
      step();
      check("tick_lowered", 32'(bus.sel_out), 32'd8);

      // tick_div=0 advances every cycle.
      bus.tick_div = 16'd0;
      step();
      check("tick0_adv1", 32'(bus.sel_out), 32'd9);
      step();
      check("tick0_adv2", 32'(bus.sel_out), 32'd10);

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         bus.en     = ($urandom_range(0, 9) != 0);
         bus.mode   = ($urandom_range(0, 3) != 0) ? MODE_SCAN : MODE_DIRECT;
         bus.load   = ($urandom_range(0, 15) == 0);
         bus.sel_in = 4'($urandom);
         if ($urandom_range(0, 19) == 0) bus.tick_div = 16'($urandom_range(0, 5));
         step();
      end

      // Reset asserted mid-dwell.
      bus.en = 1'b1; bus.mode = MODE_SCAN; bus.load = 1'b0; bus.tick_div = 16'd3;
      step();
      step();
      #3 rst = 1'b1;
      #1;
      model_update();
      check("midrst_sel",  32'(bus.sel_out), 32'd0);
      check("midrst_dout", 32'(bus.dout),    32'h0000);
      check("midrst_wrap", 32'(bus.wrap),    32'd0);
      step();
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule : tb_scan_decoder
